// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with drain counter; optional rotate via USR_ROTATE_EN
module univ_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             drained
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_inc;

    // Shift count saturates at WIDTH so drained never falls back without a load
    assign cnt_inc = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CW'(1);

`ifndef USR_ROTATE_EN
    // Rotate disabled: rot is accepted on the port but deliberately ignored
    logic unused_rot;
    assign unused_rot = rot;
`endif

    // Next-state selection for data register and shift counter
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        case (mode)
            MODE_HOLD: begin
                q_d   = q_q;
                cnt_d = cnt_q;
            end
            MODE_SHR: begin
`ifdef USR_ROTATE_EN
                if (rot) begin
                    // Rotation keeps every bit inside, so nothing counts as drained
                    q_d   = {q_q[0], q_q[WIDTH-1:1]};
                    cnt_d = cnt_q;
                end else begin
                    q_d   = {sin_r, q_q[WIDTH-1:1]};
                    cnt_d = cnt_inc;
                end
`else
                q_d   = {sin_r, q_q[WIDTH-1:1]};
                cnt_d = cnt_inc;
`endif
            end
            MODE_SHL: begin
`ifdef USR_ROTATE_EN
                if (rot) begin
                    q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    cnt_d = cnt_q;
                end else begin
                    q_d   = {q_q[WIDTH-2:0], sin_l};
                    cnt_d = cnt_inc;
                end
`else
                q_d   = {q_q[WIDTH-2:0], sin_l};
                cnt_d = cnt_inc;
`endif
            end
            MODE_LOAD: begin
                q_d   = pin;
                cnt_d = '0;
            end
            default: begin
                q_d   = q_q;
                cnt_d = cnt_q;
            end
        endcase
    end

    // State registers; reset forces an empty register that reports drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            cnt_q <= CNT_FULL;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs decode registered state only
    assign q       = q_q;
    assign sout_r  = q_q[0];
    assign sout_l  = q_q[WIDTH-1];
    assign drained = (cnt_q == CNT_FULL);

endmodule
